// File: rtl/simple_stim_driver_if.sv
// Vector request / response channels between a stimulus source and simple_stim_driver.
// The stimulus source uses the master modport; the driver uses the slave modport.
interface simple_stim_driver_if #(
    parameter int DEPTH = 16
);
    logic             vec_valid;
    logic             vec_ready;
    logic [DEPTH-1:0] vec_a;
    logic [DEPTH-1:0] vec_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DEPTH-1:0] rsp_data;

    modport master (
        output vec_valid, vec_a, vec_b, rsp_ready,
        input  vec_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  vec_valid, vec_a, vec_b, rsp_ready,
        output vec_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/simple_stim_driver.sv
// Serialises a vector pair LSB-first onto inp1/inp2 and captures the netlist's out bit per stimulus bit.
// Optional response compare (vec_exp/rsp_err) is enabled by defining SIMPLE_STIM_CMP_EN.
module simple_stim_driver #(
    parameter int DEPTH = 16,
    parameter int LAT   = 1
) (
    input  logic                 iccad_clk,
    input  logic                 iccad_rst,
    simple_stim_driver_if.slave  bus,
    output logic                 inp1,
    output logic                 inp2,
    input  logic                 out_sample,
    output logic                 busy
`ifdef SIMPLE_STIM_CMP_EN
    ,
    input  logic [DEPTH-1:0]     vec_exp,
    output logic                 rsp_err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FLUSH = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_reg,     state_next;
    logic [IDX_W-1:0] idx_reg,       idx_next;
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic [DEPTH-1:0] a_reg,         a_next;
    logic [DEPTH-1:0] b_reg,         b_next;
    logic             inp1_reg,      inp1_next;
    logic             inp2_reg,      inp2_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic [DEPTH-1:0] rsp_data_reg,  rsp_data_next;
    logic [IDX_W-1:0] cap_idx_reg,   cap_idx_next;
    logic [LAT:0]     cap_pipe_reg,  cap_pipe_next;
`ifdef SIMPLE_STIM_CMP_EN
    logic [DEPTH-1:0] exp_reg,       exp_next;
`endif

    // One token per driven bit; it reaches the last stage on the edge before out_sample carries that bit's effect.
    assign cap_pipe_next[0] = (state_reg == DRIVE);
    generate
        for (genvar gi = 1; gi <= LAT; gi++) begin : g_cap_pipe
            assign cap_pipe_next[gi] = cap_pipe_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge iccad_clk) begin
        if (iccad_rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            flush_cnt_reg <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            inp1_reg      <= 1'b0;
            inp2_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            cap_idx_reg   <= '0;
            cap_pipe_reg  <= '0;
`ifdef SIMPLE_STIM_CMP_EN
            exp_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            flush_cnt_reg <= flush_cnt_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            inp1_reg      <= inp1_next;
            inp2_reg      <= inp2_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            cap_idx_reg   <= cap_idx_next;
            cap_pipe_reg  <= cap_pipe_next;
`ifdef SIMPLE_STIM_CMP_EN
            exp_reg       <= exp_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        flush_cnt_next = flush_cnt_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        inp1_next      = inp1_reg;
        inp2_next      = inp2_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        cap_idx_next   = cap_idx_reg;
`ifdef SIMPLE_STIM_CMP_EN
        exp_next       = exp_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (bus.vec_valid) begin
                    state_next   = DRIVE;
                    a_next       = bus.vec_a;
                    b_next       = bus.vec_b;
                    idx_next     = '0;
                    cap_idx_next = '0;
`ifdef SIMPLE_STIM_CMP_EN
                    exp_next     = vec_exp;
`endif
                end
            end
            DRIVE: begin
                inp1_next = a_reg[idx_reg];
                inp2_next = b_reg[idx_reg];
                if (idx_reg == LAST_IDX) begin
                    state_next     = FLUSH;
                    flush_cnt_next = '0;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            FLUSH: begin
                // The first FLUSH cycle still shows the last bit; LAT zero cycles follow before RESP.
                inp1_next = 1'b0;
                inp2_next = 1'b0;
                if (flush_cnt_reg == LAT_CNT) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                end else begin
                    flush_cnt_next = flush_cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (cap_pipe_reg[LAT]) begin
            rsp_data_next[cap_idx_reg] = out_sample;
            cap_idx_next               = cap_idx_reg + IDX_W'(1);
        end
    end

    assign bus.vec_ready = (state_reg == IDLE);
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign inp1          = inp1_reg;
    assign inp2          = inp2_reg;
    assign busy          = (state_reg != IDLE);
`ifdef SIMPLE_STIM_CMP_EN
    assign rsp_err       = rsp_valid_reg && (rsp_data_reg != exp_reg);
`endif

endmodule

// File: tb/tb_simple_stim_driver.sv
// Directed bench for simple_stim_driver: loopback, toy netlist, backpressure, mid-run reset and LAT=3.
// Define SIMPLE_STIM_CMP_EN to also exercise the response compare.
module tb_simple_stim_driver;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             vec_valid;
    logic [DEPTH-1:0] vec_a;
    logic [DEPTH-1:0] vec_b;
    logic             rsp_ready;
    logic             sel3;
    logic             netlist_mode;
    logic [DEPTH-1:0] vec_exp;

    int checks = 0;
    int errors = 0;

    simple_stim_driver_if #(.DEPTH(DEPTH)) bus1 ();
    simple_stim_driver_if #(.DEPTH(DEPTH)) bus3 ();

    logic inp1_1, inp2_1, busy_1, out_1;
    logic inp1_3, inp2_3, busy_3, out_3;
`ifdef SIMPLE_STIM_CMP_EN
    logic rsp_err_1, rsp_err_3;
`endif

    assign bus1.vec_valid = vec_valid & ~sel3;
    assign bus1.vec_a     = vec_a;
    assign bus1.vec_b     = vec_b;
    assign bus1.rsp_ready = rsp_ready & ~sel3;
    assign bus3.vec_valid = vec_valid & sel3;
    assign bus3.vec_a     = vec_a;
    assign bus3.vec_b     = vec_b;
    assign bus3.rsp_ready = rsp_ready & sel3;

    simple_stim_driver #(.DEPTH(DEPTH), .LAT(1)) u_lat1 (
        .iccad_clk  (clk),
        .iccad_rst  (rst),
        .bus        (bus1),
        .inp1       (inp1_1),
        .inp2       (inp2_1),
        .out_sample (out_1),
        .busy       (busy_1)
`ifdef SIMPLE_STIM_CMP_EN
        ,
        .vec_exp    (vec_exp),
        .rsp_err    (rsp_err_1)
`endif
    );

    simple_stim_driver #(.DEPTH(DEPTH), .LAT(3)) u_lat3 (
        .iccad_clk  (clk),
        .iccad_rst  (rst),
        .bus        (bus3),
        .inp1       (inp1_3),
        .inp2       (inp2_3),
        .out_sample (out_3),
        .busy       (busy_3)
`ifdef SIMPLE_STIM_CMP_EN
        ,
        .vec_exp    (vec_exp),
        .rsp_err    (rsp_err_3)
`endif
    );

    // Loopback flops and the toy netlist q=(a&b)&~q_prev
    logic       lb1, nq;
    logic [2:0] lb3;
    always_ff @(posedge clk) begin
        if (rst) begin
            lb1 <= 1'b0;
            nq  <= 1'b0;
            lb3 <= '0;
        end else begin
            lb1 <= inp1_1;
            nq  <= (inp1_1 & inp2_1) & ~nq;
            lb3 <= {lb3[1:0], inp1_3};
        end
    end
    assign out_1 = netlist_mode ? nq : lb1;
    assign out_3 = lb3[2];

    logic             obs_vec_ready, obs_rsp_valid, obs_inp1, obs_inp2, obs_busy;
    logic [DEPTH-1:0] obs_rsp_data;
    assign obs_vec_ready = sel3 ? bus3.vec_ready : bus1.vec_ready;
    assign obs_rsp_valid = sel3 ? bus3.rsp_valid : bus1.rsp_valid;
    assign obs_rsp_data  = sel3 ? bus3.rsp_data  : bus1.rsp_data;
    assign obs_inp1      = sel3 ? inp1_3 : inp1_1;
    assign obs_inp2      = sel3 ? inp2_3 : inp2_1;
    assign obs_busy      = sel3 ? busy_3 : busy_1;
`ifdef SIMPLE_STIM_CMP_EN
    logic obs_rsp_err;
    assign obs_rsp_err = sel3 ? rsp_err_3 : rsp_err_1;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One request/response transaction; hold>0 keeps rsp_ready low that many cycles in RESP
    task automatic run_vec(input string tag, input logic [DEPTH-1:0] a, input logic [DEPTH-1:0] b,
                           input logic [DEPTH-1:0] expd, input int exp_lat, input int hold,
                           output logic [DEPTH-1:0] seen);
        int   cyc;
        bit   got;
        int   hold_ok;
        logic [DEPTH-1:0] held;
        seen      = '0;
        vec_a     = a;
        vec_b     = b;
        vec_valid = 1'b1;
        rsp_ready = 1'b0;
        check({tag, "_vec_ready"}, 32'(obs_vec_ready), 32'd1);
        tick();
        vec_valid = 1'b0;
        check({tag, "_busy"}, 32'(obs_busy), 32'd1);
        check({tag, "_ready_low"}, 32'(obs_vec_ready), 32'd0);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (cyc <= DEPTH) seen[cyc-1] = obs_inp1;
            if (obs_rsp_valid) got = 1'b1;
        end
        check({tag, "_latency"}, got ? 32'(cyc) : 32'd0, 32'(exp_lat));
        check({tag, "_rsp_data"}, 32'(obs_rsp_data), 32'(expd));
`ifdef SIMPLE_STIM_CMP_EN
        check({tag, "_rsp_err"}, 32'(obs_rsp_err), 32'(expd != vec_exp));
`endif
        held      = obs_rsp_data;
        hold_ok   = 0;
        vec_a     = '1;
        vec_b     = '1;
        vec_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (obs_rsp_valid && obs_rsp_data == held && !obs_vec_ready) hold_ok++;
        end
        if (hold > 0) check({tag, "_hold"}, 32'(hold_ok), 32'(hold));
        // Handshake with vec_valid still high: that vector must not be taken
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vec_valid = 1'b0;
        check({tag, "_rsp_done"}, 32'(obs_rsp_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(obs_vec_ready), 32'd1);
        check({tag, "_idle_busy"}, 32'(obs_busy), 32'd0);
        check({tag, "_data_held"}, 32'(obs_rsp_data), 32'(expd));
        $display("txn %s a=%b b=%b rsp=%b lat=%0d inp1_seq=%b", tag, a, b, held, cyc, seen);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DEPTH-1:0] seen;
        rst          = 1'b1;
        vec_valid    = 1'b0;
        vec_a        = '0;
        vec_b        = '0;
        rsp_ready    = 1'b0;
        sel3         = 1'b0;
        netlist_mode = 1'b0;
        vec_exp      = '0;
        tick();
        tick();
        check("rst_vec_ready", 32'(obs_vec_ready), 32'd1);
        check("rst_inp1", 32'(obs_inp1), 32'd0);
        check("rst_inp2", 32'(obs_inp2), 32'd0);
        check("rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(obs_rsp_data), 32'd0);
        check("rst_busy", 32'(obs_busy), 32'd0);
        rst = 1'b0;
        tick();

        run_vec("loopback", 4'b1010, 4'b0000, 4'b1010, 6, 0, seen);
        check("loopback_inp1_seq", 32'(seen), 32'b1010);

        netlist_mode = 1'b1;
        run_vec("netlist", 4'b1110, 4'b1110, 4'b1010, 6, 0, seen);
        check("netlist_inp1_seq", 32'(seen), 32'b1110);
        netlist_mode = 1'b0;

        run_vec("backpressure", 4'b0011, 4'b0101, 4'b0011, 6, 10, seen);

        // Reset while bit 2 is on the pins
        vec_a     = 4'b1111;
        vec_b     = 4'b1111;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_bit2", 32'(obs_inp1), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_inp1", 32'(obs_inp1), 32'd0);
        check("midrst_inp2", 32'(obs_inp2), 32'd0);
        check("midrst_busy", 32'(obs_busy), 32'd0);
        check("midrst_vec_ready", 32'(obs_vec_ready), 32'd1);
        check("midrst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
        check("midrst_rsp_data", 32'(obs_rsp_data), 32'd0);
        rst = 1'b0;
        tick();
        run_vec("after_rst", 4'b0101, 4'b0000, 4'b0101, 6, 0, seen);

        sel3 = 1'b1;
        run_vec("lat3", 4'b0110, 4'b0000, 4'b0110, 8, 0, seen);
        check("lat3_inp1_seq", 32'(seen), 32'b0110);
        sel3 = 1'b0;

        vec_exp = 4'b1010;
        run_vec("cmp_match", 4'b1010, 4'b0000, 4'b1010, 6, 0, seen);
        vec_exp = 4'b1011;
        run_vec("cmp_differ", 4'b1010, 4'b0000, 4'b1010, 6, 0, seen);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
